uart_tx_cfg: RTL and testbench

//  Runtime-configurable UART transmitter; successor to the fixed 8N1 TX path in the KianV SoC UART.
//  - Bytes are buffered in the existing fifo block.
//  - Framing is programmable per frame: 5-8 data bits, none/odd/even parity, 1 or 2 stop bits.
//  - Back-to-back frames are sent with zero idle gap.
//  - Sits between the UART register block and the tx pin.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/fifo.sv | 56 +++++
 rtl/uart_tx_cfg.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the configurable UART transmitter.
//   - uart_tx_state_t : transmitter FSM states
//   - UART_PAR_*      : encodings of the cfg_parity field
//   - UART_DBITS_BASE : data bits = UART_DBITS_BASE + cfg_dbits
//   - dbits_mask()    : mask of the data bits that are actually sent
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // 2'b11 is reserved and behaves like UART_PAR_NONE.
    localparam logic [1:0] UART_PAR_NONE = 2'b00;
    localparam logic [1:0] UART_PAR_ODD  = 2'b01;
    localparam logic [1:0] UART_PAR_EVEN = 2'b10;

    localparam int UART_DBITS_BASE = 5;

    // Keeps only the low 5..8 bits of a byte so that unused high bits take
    // part neither in the serial stream nor in the parity calculation.
    function automatic logic [7:0] dbits_mask(input logic [1:0] dbits);
        return 8'hFF >> (2'd3 - dbits);
    endfunction

endpackage

// File: rtl/fifo.sv
// ----------------------------------------------------------------------------
// fifo
//   Synchronous first-word-fall-through FIFO.
//   Parameters: DATA_WIDTH (entry width), DEPTH (entries, power of two, >= 2)
//   Ports:
//     clk, resetn  clock, asynchronous active-low reset (empties the FIFO)
//     push, wdata  write request and data; ignored while full
//     pop          read request; ignored while empty
//     rdata        head entry, valid whenever empty = 0
//     full, empty  status flags
// ----------------------------------------------------------------------------
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit tells full from empty when the indices match.
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_cfg.sv
// ----------------------------------------------------------------------------
// uart_tx_cfg
//   Runtime-configurable UART transmitter with a byte FIFO. Each frame is
//   start bit, 5-8 data bits LSB first, optional odd/even parity, 1 or 2 stop
//   bits. Frames leave back to back with no idle gap while data is queued.
//   Optional build macro: UART_TX_CTS_EN adds the cts_n flow-control input.
//   Parameters: FIFO_DEPTH (buffer entries), DIV_WIDTH (baud divisor width)
//   Ports:
//     clk, resetn  clock, asynchronous active-low reset
//     valid        push tx_data into the FIFO
//     tx_data      byte to send
//     div          clk cycles per bit (0 behaves as 1)
//     cfg_dbits    data bits = 5 + cfg_dbits
//     cfg_parity   00/11 none, 01 odd, 10 even
//     cfg_stop2    1 = two stop bits
//     cts_n        clear-to-send, active low (UART_TX_CTS_EN builds only)
//     tx_out       serial line, idle high
//     ready        FIFO can take a byte
//     busy         frame in flight or bytes queued
//     frame_done   high on the final cycle of the last stop bit
//   Handshake: a byte is taken on a rising clk edge where valid = 1 and
//   ready = 1; valid with ready = 0 is dropped without error.
//   div and cfg_* are sampled when a frame starts and held for its duration.
// ----------------------------------------------------------------------------
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 valid,
    input  logic [7:0]           tx_data,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [1:0]           cfg_dbits,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
`ifdef UART_TX_CTS_EN
    input  logic                 cts_n,
`endif
    output logic                 tx_out,
    output logic                 ready,
    output logic                 busy,
    output logic                 frame_done
);

    uart_tx_state_t       state;
    uart_tx_state_t       state_n;

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] cnt_n;
    logic [2:0]           bit_idx;
    logic [2:0]           bit_idx_n;
    logic                 stop_idx;
    logic                 stop_idx_n;
    logic                 tx_n;

    // Frame parameters captured when the byte is popped.
    logic [7:0]           data_q;
    logic [2:0]           dlast_q;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic                 stop2_q;
    logic [DIV_WIDTH-1:0] div_q;

    logic [7:0]           fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [7:0]           masked;
    logic                 bit_end;
    logic                 start_ok;
    logic                 cts_clear;
    logic [DIV_WIDTH-1:0] load_in;
    logic [DIV_WIDTH-1:0] load_q;

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync;

    // Resets to "not clear" so nothing starts until the peer asserts CTS.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cts_sync <= 2'b11;
        else         cts_sync <= {cts_sync[0], cts_n};
    end

    assign cts_clear = ~cts_sync[1];
`else
    assign cts_clear = 1'b1;
`endif

    fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (valid),
        .pop    (fifo_pop),
        .wdata  (tx_data),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign ready    = ~fifo_full;
    assign busy     = (state != IDLE) | ~fifo_empty;
    assign start_ok = ~fifo_empty & cts_clear;
    assign bit_end  = (cnt == '0);
    assign masked   = fifo_rdata & dbits_mask(cfg_dbits);

    // Counter reload: a divisor of 0 is treated as 1, so the load never wraps.
    assign load_in = (div == '0)   ? '0 : div - DIV_WIDTH'(1);
    assign load_q  = (div_q == '0) ? '0 : div_q - DIV_WIDTH'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx_out   <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            stop_idx <= stop_idx_n;
            tx_out   <= tx_n;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q    <= '0;
            dlast_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            div_q     <= '0;
        end else if (fifo_pop) begin
            data_q    <= masked;
            dlast_q   <= 3'(UART_DBITS_BASE - 1) + {1'b0, cfg_dbits};
            par_en_q  <= (cfg_parity == UART_PAR_ODD) || (cfg_parity == UART_PAR_EVEN);
            par_bit_q <= (cfg_parity == UART_PAR_ODD) ? ~^masked : ^masked;
            stop2_q   <= cfg_stop2;
            div_q     <= div;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = bit_end ? cnt : cnt - DIV_WIDTH'(1);
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        tx_n       = tx_out;
        fifo_pop   = 1'b0;
        frame_done = 1'b0;

        case (state)
            IDLE: begin
                tx_n  = 1'b1;
                cnt_n = '0;
                if (start_ok) begin
                    fifo_pop = 1'b1;
                    state_n  = START;
                    tx_n     = 1'b0;
                    cnt_n    = load_in;
                end
            end

            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                    tx_n      = data_q[0];
                    cnt_n     = load_q;
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_n = load_q;
                    if (bit_idx == dlast_q) begin
                        if (par_en_q) begin
                            state_n = PARITY;
                            tx_n    = par_bit_q;
                        end else begin
                            state_n    = STOP;
                            tx_n       = 1'b1;
                            stop_idx_n = 1'b0;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = data_q[bit_idx + 3'd1];
                    end
                end
            end

            PARITY: begin
                if (bit_end) begin
                    state_n    = STOP;
                    tx_n       = 1'b1;
                    stop_idx_n = 1'b0;
                    cnt_n      = load_q;
                end
            end

            STOP: begin
                tx_n = 1'b1;
                if (bit_end) begin
                    if (stop2_q && !stop_idx) begin
                        stop_idx_n = 1'b1;
                        cnt_n      = load_q;
                    end else begin
                        frame_done = 1'b1;
                        // Chain straight into the next start bit when a byte
                        // is waiting, so consecutive frames have no gap.
                        if (start_ok) begin
                            fifo_pop = 1'b1;
                            state_n  = START;
                            tx_n     = 1'b0;
                            cnt_n    = load_in;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end

            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_cfg
//   Self-checking bench for uart_tx_cfg. Expected frames are queued as
//   {div[15:0], nbits[3:0], line_bits[11:0]} (line_bits[0] is the start bit)
//   when a byte is accepted; a line monitor pops them when a start bit
//   appears and checks every cycle of the frame plus the frame_done timing.
// ----------------------------------------------------------------------------
module tb_uart_tx_cfg;

    localparam int FIFO_DEPTH = 16;
    localparam int DIV_WIDTH  = 16;

    logic                 clk        = 1'b0;
    logic                 resetn     = 1'b0;
    logic                 valid      = 1'b0;
    logic [7:0]           tx_data    = 8'h00;
    logic [DIV_WIDTH-1:0] div        = 16'd1;
    logic [1:0]           cfg_dbits  = 2'd3;
    logic [1:0]           cfg_parity = 2'b00;
    logic                 cfg_stop2  = 1'b0;
`ifdef UART_TX_CTS_EN
    logic                 cts_n      = 1'b0;
`endif
    logic                 tx_out;
    logic                 ready;
    logic                 busy;
    logic                 frame_done;

    uart_tx_cfg #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_WIDTH  (DIV_WIDTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .valid      (valid),
        .tx_data    (tx_data),
        .div        (div),
        .cfg_dbits  (cfg_dbits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
`ifdef UART_TX_CTS_EN
        .cts_n      (cts_n),
`endif
        .tx_out     (tx_out),
        .ready      (ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    int          start_cyc[$];
    int          done_cyc[$];
    int          cyc = 0;
    int          nstart = 0;
    int          ndone = 0;
    bit          mon_active = 1'b0;
    int          mon_k = 0;
    int          mon_bad = 0;
    logic [31:0] mon_cur = '0;
    logic        prev_tx = 1'b1;

    // Reference frame builder: start, data LSB first, parity, stops.
    function automatic logic [31:0] model(input logic [7:0] d, input logic [1:0] db,
                                          input logic [1:0] par, input logic s2,
                                          input logic [15:0] dv);
        logic [11:0] b;
        int          n;
        logic        p;
        b = '0;
        p = 1'b0;
        b[0] = 1'b0;
        n = 1;
        for (int i = 0; i < 5 + int'(db); i++) begin
            b[n] = d[i];
            p    = p ^ d[i];
            n++;
        end
        if (par == 2'b01) begin
            b[n] = ~p;
            n++;
        end else if (par == 2'b10) begin
            b[n] = p;
            n++;
        end
        b[n] = 1'b1;
        n++;
        if (s2) begin
            b[n] = 1'b1;
            n++;
        end
        return {dv, 4'(n), b};
    endfunction

    // ---------------- line monitor ----------------
    always begin
        int divc;
        int len;
        @(posedge clk);
        #2;
        cyc++;
        if (!resetn) begin
            mon_active = 1'b0;
            prev_tx    = 1'b1;
        end else begin
            if (!mon_active && frame_done === 1'b1) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_frame_done cyc=%0d got 1 want 0", cyc);
            end
            if (!mon_active && prev_tx === 1'b1 && tx_out === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_frame cyc=%0d got start bit want idle line", cyc);
                end else begin
                    mon_cur    = exp_q.pop_front();
                    mon_active = 1'b1;
                    mon_k      = 0;
                    mon_bad    = 0;
                    start_cyc.push_back(cyc);
                    nstart++;
                end
            end
            if (mon_active) begin
                divc = (mon_cur[31:16] == 16'd0) ? 1 : int'(mon_cur[31:16]);
                len  = int'(mon_cur[15:12]) * divc;
                if (tx_out !== mon_cur[mon_k / divc]) mon_bad++;
                if (frame_done !== (mon_k == len - 1)) mon_bad++;
                if (mon_k == len - 1) begin
                    n_vec++;
                    done_cyc.push_back(cyc);
                    ndone++;
                    mon_active = 1'b0;
                    if (mon_bad != 0) begin
                        n_err++;
                        $display("FAIL frame #%0d got %0d bad cycles want 0 (bits=%h nbits=%0d div=%0d)",
                                 ndone, mon_bad, mon_cur[11:0], mon_cur[15:12], divc);
                    end
                end
                mon_k++;
            end
            prev_tx = tx_out;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #4;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic set_cfg(input logic [1:0] db, input logic [1:0] par,
                           input logic s2, input logic [15:0] dv);
        cfg_dbits  = db;
        cfg_parity = par;
        cfg_stop2  = s2;
        div        = dv;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic [31:0] expf, output bit acc);
        valid   = 1'b1;
        tx_data = d;
        acc     = ready;
        if (ready) exp_q.push_back(expf);
        step();
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() != 0 || mon_active) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout got %0d pending frames want 0", name,
                     exp_q.size() + int'(mon_active));
            exp_q.delete();
            mon_active = 1'b0;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  data;
        logic [1:0]  dbits;
        logic [1:0]  parity;
        logic        stop2;
        logic [15:0] divv;
        logic [11:0] bits;
        int          nbits;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit acc;
        int ns0;
        int nd0;
        int base;
        int sbase;
        int n;
        int acc_cnt;
        int exp_acc;
        bit busy_ok;
        bit saw_full;
        logic [7:0]  d;
        logic [1:0]  db;
        logic [1:0]  par;
        logic        s2;
        logic [15:0] dv;

        vecs[0] = '{8'h55, 2'd3, 2'b00, 1'b0, 16'd4, 12'h2AA, 10};  // 8N1
        vecs[1] = '{8'h41, 2'd2, 2'b10, 1'b1, 16'd3, 12'h682, 11};  // 7E2
        vecs[2] = '{8'hFF, 2'd0, 2'b01, 1'b0, 16'd2, 12'h0BE, 8};   // 5O1
        vecs[3] = '{8'h2A, 2'd1, 2'b00, 1'b0, 16'd1, 12'h0D4, 8};   // 6N1
        vecs[4] = '{8'hA5, 2'd3, 2'b10, 1'b0, 16'd0, 12'h54A, 11};  // 8E1, div 0
        vecs[5] = '{8'h3C, 2'd3, 2'b11, 1'b1, 16'd2, 12'h678, 11};  // reserved parity
        vecs[6] = '{8'hF3, 2'd0, 2'b10, 1'b1, 16'd1, 12'h1E6, 9};   // 5E2

        // ---- reset ----
        step();
        step();
        check("rst_tx_out", {31'd0, tx_out}, 32'd1);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        resetn = 1'b1;
        step();
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // ---- table-driven frames ----
        for (int i = 0; i < 7; i++) begin
            set_cfg(vecs[i].dbits, vecs[i].parity, vecs[i].stop2, vecs[i].divv);
            ns0 = start_cyc.size();
            nd0 = done_cyc.size();
            push_byte(vecs[i].data, {vecs[i].divv, 4'(vecs[i].nbits), vecs[i].bits}, acc);
            check($sformatf("vec%0d_accept", i), {31'd0, acc}, 32'd1);
            wait_idle(300, $sformatf("vec%0d", i));
            if (start_cyc.size() == ns0 + 1 && done_cyc.size() == nd0 + 1) begin
                check($sformatf("vec%0d_len", i), done_cyc[nd0] - start_cyc[ns0] + 1,
                      vecs[i].nbits * ((vecs[i].divv == 16'd0) ? 1 : int'(vecs[i].divv)));
            end else begin
                n_vec++;
                n_err++;
                $display("FAIL vec%0d_len got %0d frames want 1", i, done_cyc.size() - nd0);
            end
        end

        // ---- random framings against the reference model ----
        for (int i = 0; i < 8; i++) begin
            d   = 8'($urandom_range(0, 255));
            db  = 2'($urandom_range(0, 3));
            par = 2'($urandom_range(0, 3));
            s2  = 1'($urandom_range(0, 1));
            dv  = 16'($urandom_range(0, 3));
            set_cfg(db, par, s2, dv);
            push_byte(d, model(d, db, par, s2, dv), acc);
            wait_idle(300, $sformatf("rand%0d", i));
        end

        // ---- back-to-back frames ----
        set_cfg(2'd3, 2'b00, 1'b0, 16'd2);
        base  = done_cyc.size();
        sbase = start_cyc.size();
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom_range(0, 255));
            push_byte(d, model(d, 2'd3, 2'b00, 1'b0, 16'd2), acc);
        end
        busy_ok = 1'b1;
        n = 0;
        while (done_cyc.size() < base + 3 && n < 400) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            step();
            n++;
        end
        check("b2b_busy_held", {31'd0, busy_ok}, 32'd1);
        check("b2b_busy_last_done", {31'd0, busy}, 32'd1);
        step();
        check("b2b_busy_drop", {31'd0, busy}, 32'd0);
        if (start_cyc.size() >= sbase + 3 && done_cyc.size() >= base + 2) begin
            check("b2b_gap_1_2", start_cyc[sbase + 1], done_cyc[base] + 1);
            check("b2b_gap_2_3", start_cyc[sbase + 2], done_cyc[base + 1] + 1);
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL b2b_frames got %0d starts want 3", start_cyc.size() - sbase);
        end
        wait_idle(100, "b2b");

        // ---- FIFO fill and overflow ----
        set_cfg(2'd3, 2'b00, 1'b0, 16'd2);
`ifdef UART_TX_CTS_EN
        cts_n = 1'b1;
        repeat (4) step();
        exp_acc = FIFO_DEPTH;
`else
        // The first byte is popped into the shifter while the rest arrive.
        exp_acc = FIFO_DEPTH + 1;
`endif
        sbase    = nstart;
        acc_cnt  = 0;
        saw_full = 1'b0;
        for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
            d = 8'($urandom_range(0, 255));
            push_byte(d, model(d, 2'd3, 2'b00, 1'b0, 16'd2), acc);
            acc_cnt += int'(acc);
            if (!acc) saw_full = 1'b1;
        end
        check("fill_accepted", acc_cnt, exp_acc);
        check("fill_saw_ready_low", {31'd0, saw_full}, 32'd1);
        check("fill_ready_now", {31'd0, ready}, 32'd0);
`ifdef UART_TX_CTS_EN
        cts_n = 1'b0;
`endif
        wait_idle((FIFO_DEPTH + 3) * 25, "fill");
        check("fill_frames", nstart - sbase, exp_acc);
        check("fill_ready_after", {31'd0, ready}, 32'd1);

        // ---- reset in the middle of data bit 3 ----
        set_cfg(2'd3, 2'b00, 1'b0, 16'd4);
        sbase = nstart;
        push_byte(8'h5A, model(8'h5A, 2'd3, 2'b00, 1'b0, 16'd4), acc);
        n = 0;
        while (!(mon_active && mon_k == 18) && n < 100) begin
            step();
            n++;
        end
        check("rst_mid_reached_d3", {31'd0, (mon_active && mon_k == 18)}, 32'd1);
        resetn = 1'b0;
        #1;
        check("rst_mid_tx_out", {31'd0, tx_out}, 32'd1);
        check("rst_mid_frame_done", {31'd0, frame_done}, 32'd0);
        step();
        step();
        resetn = 1'b1;
        exp_q.delete();
        step();
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_ready", {31'd0, ready}, 32'd1);
        check("rst_mid_line", {31'd0, tx_out}, 32'd1);
        repeat (60) step();
        check("rst_mid_no_frame", nstart - sbase, 1);

`ifdef UART_TX_CTS_EN
        // ---- CTS gating and synchronizer latency ----
        cts_n = 1'b1;
        repeat (4) step();
        sbase = nstart;
        push_byte(8'h96, model(8'h96, 2'd3, 2'b00, 1'b0, 16'd2), acc);
        repeat (10) step();
        check("cts_blocked", nstart - sbase, 0);
        cts_n = 1'b0;
        n = 0;
        while (nstart == sbase && n < 10) begin
            step();
            n++;
        end
        check("cts_latency", n, 3);
        wait_idle(100, "cts");
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
